// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone shared-bus interconnect.
//   state_t  : bus FSM encoding (IDLE=0, BUSY=1)
//   TMR_W    : width of the per-transfer ack timeout counter
//   clog2    : ceiling log2 for parameter arithmetic
//   idx_w    : index width for n items, at least 1 bit
//   lane_lsb : base bit of lane k in a bus of packed w-bit lanes
package wb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int unsigned TMR_W = 8;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  // Keeps index ports legal when there is only one item.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin request picker, purely combinational.
//   req       : one request bit per master
//   ptr       : highest-priority index this round
//   gnt_oh_c  : one-hot winner
//   gnt_idx_c : winner index
//   gnt_any_c : at least one request present
module wb_rr_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned NM = 2,
  localparam int unsigned IW = idx_w(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] ptr,
  output logic [NM-1:0] gnt_oh_c,
  output logic [IW-1:0] gnt_idx_c,
  output logic          gnt_any_c
);

  // Scan ptr, ptr+1, ... (mod NM); first requester wins.
  always_comb begin
    gnt_oh_c  = '0;
    gnt_idx_c = '0;
    gnt_any_c = 1'b0;
    for (int unsigned i = 0; i < NM; i++) begin
      for (int unsigned j = 0; j < NM; j++) begin
        if (!gnt_any_c && req[j] && (((32'(ptr) + i) % NM) == j)) begin
          gnt_oh_c[j] = 1'b1;
          gnt_idx_c   = IW'(j);
          gnt_any_c   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_shared_bus.sv
// Wishbone B3 classic shared-bus interconnect: NM masters, NS slaves, one
// shared data path, round-robin arbitration, address-field slave decode,
// error on unmapped addresses and a per-transfer ack timeout.
//   wb_clk_i, wb_rst_i          : clock, async active-high reset
//   m_cyc/stb/we/sel/adr/dat_i  : packed master requests (lane k per master)
//   m_dat_o, m_ack_o, m_err_o   : broadcast read data, per-master ack/err
//   s_cyc_o, s_stb_o            : per-slave cycle/strobe
//   s_we/sel/adr/dat_o          : shared request from the granted master
//   s_dat_i, s_ack_i, s_err_i   : packed slave responses
//   gnt_o                       : registered one-hot grant
module wb_shared_bus
  import wb_pkg::*;
#(
  parameter int unsigned NM      = 2,
  parameter int unsigned NS      = 4,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned SW      = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [NM-1:0]        m_cyc_i,
  input  logic [NM-1:0]        m_stb_i,
  input  logic [NM-1:0]        m_we_i,
  input  logic [NM*DW/8-1:0]   m_sel_i,
  input  logic [NM*AW-1:0]     m_adr_i,
  input  logic [NM*DW-1:0]     m_dat_i,
  output logic [DW-1:0]        m_dat_o,
  output logic [NM-1:0]        m_ack_o,
  output logic [NM-1:0]        m_err_o,
  output logic [NS-1:0]        s_cyc_o,
  output logic [NS-1:0]        s_stb_o,
  output logic                 s_we_o,
  output logic [DW/8-1:0]      s_sel_o,
  output logic [AW-1:0]        s_adr_o,
  output logic [DW-1:0]        s_dat_o,
  input  logic [NS*DW-1:0]     s_dat_i,
  input  logic [NS-1:0]        s_ack_i,
  input  logic [NS-1:0]        s_err_i,
  output logic [NM-1:0]        gnt_o
);

  localparam int unsigned IW   = idx_w(NM);
  localparam int unsigned SELW = DW / 8;

  // Elaboration-time parameter sanity.
  if (NS >= (32'd1 << SW)) begin : g_chk_ns
    $error("NS must be below 2**SW");
  end
  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_chk_tmo
    $error("TIMEOUT must be in 1..255");
  end
  if ((DW % 8) != 0) begin : g_chk_dw
    $error("DW must be a multiple of 8");
  end

  state_t            state_q, state_d;
  logic [IW-1:0]     g_q, g_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [NM-1:0]     gnt_d;

  logic [NM-1:0]     arb_oh;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;

  logic              mcyc, mstb, mwe;
  logic [SELW-1:0]   msel;
  logic [AW-1:0]     madr;
  logic [DW-1:0]     mdat;
  logic [SW-1:0]     sidx;
  logic              mapped;
  logic              sack, serr;
  logic [DW-1:0]     srdat;
  logic              tmo;

  wb_rr_arbiter #(.NM(NM)) u_arb (
    .req       (m_cyc_i),
    .ptr       (rr_q),
    .gnt_oh_c  (arb_oh),
    .gnt_idx_c (arb_idx),
    .gnt_any_c (arb_any)
  );

  // Request fields of the granted master.
  always_comb begin
    mcyc = 1'b0;
    mstb = 1'b0;
    mwe  = 1'b0;
    msel = '0;
    madr = '0;
    mdat = '0;
    for (int unsigned k = 0; k < NM; k++) begin
      if (32'(g_q) == k) begin
        mcyc = m_cyc_i[k];
        mstb = m_stb_i[k];
        mwe  = m_we_i[k];
        msel = m_sel_i[lane_lsb(k, SELW) +: SELW];
        madr = m_adr_i[lane_lsb(k, AW) +: AW];
        mdat = m_dat_i[lane_lsb(k, DW) +: DW];
      end
    end
  end

  assign sidx   = madr[AW-1 -: SW];
  assign mapped = (32'(sidx) < NS);
  assign tmo    = (tmr_q == TMR_W'(TIMEOUT));

  // Response of the decoded slave; all zero when unmapped.
  always_comb begin
    sack  = 1'b0;
    serr  = 1'b0;
    srdat = '0;
    for (int unsigned j = 0; j < NS; j++) begin
      if (mapped && (32'(sidx) == j)) begin
        sack  = s_ack_i[j];
        serr  = s_err_i[j];
        srdat = s_dat_i[lane_lsb(j, DW) +: DW];
      end
    end
  end

  // Next state, bookkeeping and bus routing.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    rr_d    = rr_q;
    gnt_d   = gnt_o;
    tmr_d   = '0;
    m_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    s_cyc_o = '0;
    s_stb_o = '0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          g_d     = arb_idx;
          gnt_d   = arb_oh;
          state_d = BUSY;
        end
      end

      BUSY: begin
        s_we_o  = mwe;
        s_sel_o = msel;
        s_adr_o = madr;
        s_dat_o = mdat;
        m_dat_o = srdat;
        for (int unsigned j = 0; j < NS; j++) begin
          if (mapped && (32'(sidx) == j)) begin
            s_cyc_o[j] = mcyc;
            s_stb_o[j] = mstb & ~tmo;
          end
        end
        // Ack beats a coincident timeout; unmapped strobes err at once.
        for (int unsigned k = 0; k < NM; k++) begin
          if (32'(g_q) == k) begin
            m_ack_o[k] = sack;
            m_err_o[k] = serr | (tmo & ~sack) | (mstb & ~mapped);
          end
        end
        // Timer runs only while a mapped strobe waits; tmo itself clears it.
        if (mstb && mapped && !sack && !serr && !tmo) begin
          tmr_d = tmr_q + TMR_W'(1);
        end
        if (!mcyc) begin
          state_d = IDLE;
          rr_d    = IW'((32'(g_q) + 32'd1) % NM);
          gnt_d   = '0;
          tmr_d   = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      g_q     <= '0;
      rr_q    <= '0;
      tmr_q   <= '0;
      gnt_o   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
      tmr_q   <= tmr_d;
      gnt_o   <= gnt_d;
    end
  end

endmodule

// File: tb/tb_wb_shared_bus.sv
// Self-checking bench for wb_shared_bus (NM=2, NS=4, TIMEOUT=255).
module tb_wb_shared_bus;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [7:0]    m_sel_i;
  logic [63:0]   m_adr_i, m_dat_i;
  logic [31:0]   m_dat_o;
  logic [1:0]    m_ack_o, m_err_o;
  logic [3:0]    s_cyc_o, s_stb_o;
  logic          s_we_o;
  logic [3:0]    s_sel_o;
  logic [31:0]   s_adr_o, s_dat_o;
  logic [127:0]  s_dat_i;
  logic [3:0]    s_ack_i, s_err_i;
  logic [1:0]    gnt_o;

  logic [3:0]    ack_en, ack_force, err_en;
  int            n_chk = 0;
  int            n_fail = 0;
  int            exp_rr = 0;

  always #5 clk = ~clk;

  // Slaves respond combinationally while strobed.
  assign s_ack_i = (ack_en & s_cyc_o & s_stb_o) | ack_force;
  assign s_err_i = err_en & s_cyc_o & s_stb_o;

  wb_shared_bus dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m_cyc_i  (m_cyc_i),
    .m_stb_i  (m_stb_i),
    .m_we_i   (m_we_i),
    .m_sel_i  (m_sel_i),
    .m_adr_i  (m_adr_i),
    .m_dat_i  (m_dat_i),
    .m_dat_o  (m_dat_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_sel_o  (s_sel_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i),
    .s_err_i  (s_err_i),
    .gnt_o    (gnt_o)
  );

  typedef struct {
    int          m;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        serr;
    logic [3:0]  exp_stb;
    logic [1:0]  exp_ack;
    logic [1:0]  exp_err;
    logic [31:0] exp_rdat;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    m_cyc_i[m]          = cyc;
    m_stb_i[m]          = stb;
    m_we_i[m]           = we;
    m_sel_i[m*4 +: 4]   = sel;
    m_adr_i[m*32 +: 32] = adr;
    m_dat_i[m*32 +: 32] = dat;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 64'({m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, gnt_o}), 64'd0);
    chk({tag, "_adr"}, 64'(s_adr_o), 64'd0);
    chk({tag, "_wdat"}, 64'(s_dat_o), 64'd0);
    chk({tag, "_rdat"}, 64'(m_dat_o), 64'd0);
  endtask

  // One single-beat transfer by one master, checked in its only BUSY cycle.
  task automatic run_vec(input vec_t v, input string tag);
    logic [1:0] mbit;
    mbit = 2'b01 << v.m;
    @(posedge clk); #1;
    drive_m(v.m, 1'b1, 1'b1, v.we, v.adr, v.dat, v.sel);
    err_en = v.serr ? 4'hF : 4'h0;
    @(negedge clk);
    chk({tag, "_prearb_stb"}, 64'(s_stb_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_gnt"},  64'(gnt_o),   64'(mbit));
    chk({tag, "_stb"},  64'(s_stb_o), 64'(v.exp_stb));
    chk({tag, "_cyc"},  64'(s_cyc_o), 64'(v.exp_stb));
    chk({tag, "_adr"},  64'(s_adr_o), 64'(v.adr));
    chk({tag, "_we"},   64'(s_we_o),  64'(v.we));
    chk({tag, "_sel"},  64'(s_sel_o), 64'(v.sel));
    chk({tag, "_wdat"}, 64'(s_dat_o), 64'(v.dat));
    chk({tag, "_ack"},  64'(m_ack_o), 64'(v.exp_ack));
    chk({tag, "_err"},  64'(m_err_o), 64'(v.exp_err));
    chk({tag, "_rdat"}, 64'(m_dat_o), 64'(v.exp_rdat));
    @(posedge clk); #1;
    drive_m(v.m, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    err_en = 4'h0;
    @(posedge clk); #1;
    exp_rr = (v.m + 1) % 2;
  endtask

  // Slave 2 never acks; err must appear only when the timer hits 255.
  task automatic tmo_run(input logic force_ack, input string tag);
    int bad;
    bad = 0;
    ack_en = 4'b1011;
    @(posedge clk); #1;
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h2000_0000, 32'd0, 4'hF);
    @(posedge clk);
    for (int c = 0; c < 255; c++) begin
      @(negedge clk);
      if (m_err_o !== 2'b00 || m_ack_o !== 2'b00 || s_stb_o !== 4'b0100) bad++;
    end
    chk({tag, "_quiet"}, 64'(bad), 64'd0);
    @(posedge clk); #1;
    ack_force = force_ack ? 4'b0100 : 4'b0000;
    @(negedge clk);
    chk({tag, "_err"}, 64'(m_err_o), force_ack ? 64'd0 : 64'd1);
    chk({tag, "_ack"}, 64'(m_ack_o), force_ack ? 64'd1 : 64'd0);
    chk({tag, "_stb"}, 64'(s_stb_o), 64'd0);
    chk({tag, "_cyc"}, 64'(s_cyc_o), 64'h4);
    @(posedge clk); #1;
    ack_force = 4'b0000;
    @(negedge clk);
    chk({tag, "_err_after"}, 64'(m_err_o), 64'd0);
    chk({tag, "_stb_after"}, 64'(s_stb_o), 64'h4);
    @(posedge clk); #1;
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(posedge clk); #1;
    ack_en = 4'hF;
    exp_rr = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t sv;
    int   first, other;

    rst = 1'b1;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_sel_i = '0; m_adr_i = '0; m_dat_i = '0;
    ack_en = 4'hF; ack_force = 4'h0; err_en = 4'h0;
    for (int j = 0; j < 4; j++) s_dat_i[j*32 +: 32] = 32'hC0DE_0000 | 32'(j * 17);

    vecs[0] = '{0, 1'b1, 32'h1000_0040, 32'hDEAD_BEEF, 4'hF, 1'b0, 4'b0010, 2'b01, 2'b00, 32'hC0DE_0011};
    vecs[1] = '{1, 1'b0, 32'h2000_0010, 32'h0000_0000, 4'hF, 1'b0, 4'b0100, 2'b10, 2'b00, 32'hC0DE_0022};
    vecs[2] = '{0, 1'b0, 32'h0000_0004, 32'h0000_0000, 4'hF, 1'b0, 4'b0001, 2'b01, 2'b00, 32'hC0DE_0000};
    vecs[3] = '{1, 1'b0, 32'h7000_0000, 32'h0000_0000, 4'hF, 1'b0, 4'b0000, 2'b00, 2'b10, 32'h0000_0000};
    vecs[4] = '{0, 1'b1, 32'h3FFF_FFFC, 32'h1234_5678, 4'h3, 1'b0, 4'b1000, 2'b01, 2'b00, 32'hC0DE_0033};
    vecs[5] = '{0, 1'b0, 32'h4000_0000, 32'h0000_0000, 4'hF, 1'b0, 4'b0000, 2'b00, 2'b01, 32'h0000_0000};
    vecs[6] = '{1, 1'b1, 32'h3000_0100, 32'hA5A5_5A5A, 4'hC, 1'b1, 4'b1000, 2'b10, 2'b10, 32'hC0DE_0033};
    vecs[7] = '{0, 1'b0, 32'hF000_0000, 32'h0000_0000, 4'hF, 1'b0, 4'b0000, 2'b00, 2'b01, 32'h0000_0000};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("post_reset_idle");

    // Directed single transfers.
    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Timeout pulse, then ack coinciding with timeout.
    tmo_run(1'b0, "tmo");
    tmo_run(1'b1, "tmo_ackwins");

    // Master 0 holds the bus across three reads while master 1 waits.
    @(posedge clk); #1;
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'd0, 4'hF);
    @(posedge clk); #1;
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'd0, 4'hF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_gnt", k), 64'(gnt_o), 64'd1);
      chk($sformatf("hold%0d_ack", k), 64'(m_ack_o), 64'd1);
      chk($sformatf("hold%0d_adr", k), 64'(s_adr_o), 64'(k * 4));
      @(posedge clk); #1;
      if (k < 2) m_adr_i[31:0] = 32'((k + 1) * 4);
      else       m_stb_i[0] = 1'b0;
    end
    @(negedge clk);
    chk("hold_gap_gnt", 64'(gnt_o), 64'd1);
    chk("hold_gap_ack", 64'(m_ack_o), 64'd0);
    chk("hold_gap_stb", 64'(s_stb_o), 64'd0);
    @(posedge clk); #1;
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("hold_m1_gnt", 64'(gnt_o), 64'd2);
    chk("hold_m1_ack", 64'(m_ack_o), 64'd2);
    @(posedge clk); #1;
    drive_m(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(posedge clk); #1;
    exp_rr = 0;

    // Round-robin alternation: simultaneous requests, then a solo transfer.
    for (int r = 0; r < 4; r++) begin
      first = exp_rr;
      other = 1 - first;
      @(posedge clk); #1;
      drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'd0, 4'hF);
      drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'd0, 4'hF);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rr%0d_first_gnt", r), 64'(gnt_o), 64'(2'b01 << first));
      chk($sformatf("rr%0d_first_ack", r), 64'(m_ack_o), 64'(2'b01 << first));
      @(posedge clk); #1;
      drive_m(first, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rr%0d_release", r), 64'(gnt_o), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rr%0d_second_gnt", r), 64'(gnt_o), 64'(2'b01 << other));
      @(posedge clk); #1;
      drive_m(other, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      @(posedge clk); #1;
      sv = '{first, 1'b0, 32'h0000_0000, 32'd0, 4'hF, 1'b0, 4'b0001,
             2'(2'b01 << first), 2'b00, 32'hC0DE_0000};
      run_vec(sv, $sformatf("rr%0d_solo", r));
    end

    // Reset mid-transfer after leaving the pointer at master 1.
    sv = '{0, 1'b0, 32'h0000_0000, 32'd0, 4'hF, 1'b0, 4'b0001, 2'b01, 2'b00, 32'hC0DE_0000};
    run_vec(sv, "prerst");
    ack_en = 4'b0111;
    @(posedge clk); #1;
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h3000_0000, 32'd0, 4'hF);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_stb_before", 64'(s_stb_o), 64'h8);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    ack_en = 4'hF;
    @(posedge clk); #1;
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'd0, 4'hF);
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'd0, 4'hF);
    @(posedge clk);
    @(negedge clk);
    chk("postrst_gnt", 64'(gnt_o), 64'd1);
    @(posedge clk); #1;
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive_m(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
